// File: rtl/sd_adc_decimator.sv
// Third-order CIC (sinc^3) decimator: 1-bit PDM in, saturated signed 16-bit PCM out.
// Integrators run on i_ce; comb and scale stages run on the decimation strobe, two clocks of fixed latency.
module sd_adc_decimator #(
    parameter int DECIM_LOG2 = 6
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_ce,
    input  logic               i_bit,
    output logic signed [15:0] o_pcm,
    output logic               o_valid,
    output logic               o_sat
);

    localparam int W  = 2 + 3 * DECIM_LOG2;
    localparam int SH = 3 * DECIM_LOG2 - 15;
    localparam logic signed [W-1:0] PCM_MAX = W'(32767);
    localparam logic signed [W-1:0] PCM_MIN = W'(-32768);

    logic [W-1:0]          int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
    logic [W-1:0]          dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
    logic [W-1:0]          comb_q, comb_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  dec_q, dec_d;
    logic                  comb_vld_q, comb_vld_d;
    logic [1:0]            warm_q, warm_d;
    logic signed [15:0]    pcm_q, pcm_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;

    logic [W-1:0]          x;
    logic [W-1:0]          c1, c2, c3;
    logic signed [W-1:0]   scaled;

    always_comb begin
        int1_d     = int1_q;
        int2_d     = int2_q;
        int3_d     = int3_q;
        cnt_d      = cnt_q;
        dly1_d     = dly1_q;
        dly2_d     = dly2_q;
        dly3_d     = dly3_q;
        comb_d     = comb_q;
        warm_d     = warm_q;
        pcm_d      = pcm_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;

        // Integrator arithmetic wraps mod 2**W; the combs undo the wrap exactly.
        x = i_bit ? W'(1) : '1;
        if (i_ce) begin
            int1_d = int1_q + x;
            int2_d = int2_q + int1_q;
            int3_d = int3_q + int2_q;
            cnt_d  = cnt_q + DECIM_LOG2'(1);
        end
        dec_d = i_ce && (cnt_q == '1);

        c1 = int3_q - dly1_q;
        c2 = c1 - dly2_q;
        c3 = c2 - dly3_q;
        comb_vld_d = dec_q;
        if (dec_q) begin
            dly1_d = int3_q;
            dly2_d = c1;
            dly3_d = c2;
            comb_d = c3;
        end

        scaled = $signed(comb_q) >>> SH;
        // The first three decimated results come from a partially filled filter and are dropped.
        if (comb_vld_q) begin
            if (warm_q == 2'd3) begin
                valid_d = 1'b1;
                if (scaled > PCM_MAX) begin
                    pcm_d = 16'sh7FFF;
                    sat_d = 1'b1;
                end else if (scaled < PCM_MIN) begin
                    pcm_d = -16'sh8000;
                    sat_d = 1'b1;
                end else begin
                    pcm_d = scaled[15:0];
                    sat_d = 1'b0;
                end
            end else begin
                warm_d = warm_q + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            int1_q     <= '0;
            int2_q     <= '0;
            int3_q     <= '0;
            cnt_q      <= '0;
            dec_q      <= 1'b0;
            dly1_q     <= '0;
            dly2_q     <= '0;
            dly3_q     <= '0;
            comb_q     <= '0;
            comb_vld_q <= 1'b0;
            warm_q     <= 2'd0;
            pcm_q      <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            int1_q     <= int1_d;
            int2_q     <= int2_d;
            int3_q     <= int3_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            dly1_q     <= dly1_d;
            dly2_q     <= dly2_d;
            dly3_q     <= dly3_d;
            comb_q     <= comb_d;
            comb_vld_q <= comb_vld_d;
            warm_q     <= warm_d;
            pcm_q      <= pcm_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign o_pcm   = pcm_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule
